// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : branch_redirect_ctrl
// Description : Redirect/flush controller for a 5-stage in-order pipeline.
//               It samples the EX-stage branch decision and steers fetch to
//               the resolved target. At the same time it flushes the
//               wrong-path instructions held in IF/ID, ID/EX and EX/MEM.
//               A conditional-branch/JAL target with bit 0 set is treated
//               as a misaligned target: fetch goes to TRAP_VEC and a sticky
//               error flag is set.
//
// Ports       :
//   clk            in   single clock, rising-edge
//   rst            in   synchronous active-high reset
//   ex_valid       in   EX stage holds a valid instruction
//   ex_branch      in   2'd1 taken branch/JAL, 2'd2 JALR, others none
//   ex_target      in   PC+imm target (code 1)
//   ex_jalr_target in   ALU result (code 2)
//   stall          in   pipeline freeze
//   pc_sel         out  select pc_target as next fetch PC
//   pc_target      out  redirect PC (holds last latched value in IDLE)
//   flush_ifid     out  clear IF/ID
//   flush_idex     out  clear ID/EX
//   flush_exmem    out  clear EX/MEM
//   busy           out  controller is in REDIRECT or TRAP
//   misalign_err   out  sticky misaligned-target flag
//   redirect_count out  saturating count of completed redirects
//
// Revision    : 1.0 - initial release
//==============================================================================
module branch_redirect_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [1:0]       ex_branch,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_jalr_target,
    input  logic             stall,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);

    // Explicit 2-bit encoding; the unused code 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    localparam logic [1:0]       c_BR_BRANCH = 2'd1;
    localparam logic [1:0]       c_BR_JALR   = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [31:0]      r_target;
    logic             r_pc_sel;
    logic             r_flush_ifid;
    logic             r_flush_idex;
    logic             r_flush_exmem;
    logic             r_busy;
    logic             r_misalign_err;
    logic [CNT_W-1:0] r_count;

    logic             w_is_branch;
    logic             w_is_jalr;
    logic             w_take;
    logic             w_misalign;
    logic [31:0]      w_jalr_target;
    logic [31:0]      w_new_target;

    // The decision is only sampled from IDLE on an advancing cycle. In
    // REDIRECT/TRAP the EX instruction is wrong-path and is ignored.
    assign w_is_branch   = (ex_branch == c_BR_BRANCH);
    assign w_is_jalr     = (ex_branch == c_BR_JALR);
    assign w_take        = ex_valid && !stall && (w_is_branch || w_is_jalr);
    // JALR clears bit 0 of its target, so only code 1 can be misaligned.
    assign w_misalign    = w_is_branch && ex_target[0];
    assign w_jalr_target = ex_jalr_target & ~32'h0000_0001;

    always_comb begin
        w_new_target = ex_target;
        if (w_is_jalr) begin
            w_new_target = w_jalr_target;
        end else if (w_misalign) begin
            w_new_target = TRAP_VEC;
        end
    end

    // Every output comes from a register, so no input reaches an output
    // combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_target       <= 32'h0000_0000;
            r_pc_sel       <= 1'b0;
            r_flush_ifid   <= 1'b0;
            r_flush_idex   <= 1'b0;
            r_flush_exmem  <= 1'b0;
            r_busy         <= 1'b0;
            r_misalign_err <= 1'b0;
            r_count        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_target      <= w_new_target;
                        r_pc_sel      <= 1'b1;
                        r_flush_ifid  <= 1'b1;
                        r_flush_idex  <= 1'b1;
                        r_flush_exmem <= 1'b1;
                        r_busy        <= 1'b1;
                        if (w_misalign) begin
                            r_misalign_err <= 1'b1;
                            r_state        <= ST_TRAP;
                        end else begin
                            r_state        <= ST_REDIRECT;
                        end
                    end
                end

                ST_REDIRECT, ST_TRAP: begin
                    // While stalled the redirect has not been consumed yet.
                    // In that case outputs and target stay as they are.
                    if (!stall) begin
                        r_state       <= ST_IDLE;
                        r_pc_sel      <= 1'b0;
                        r_flush_ifid  <= 1'b0;
                        r_flush_idex  <= 1'b0;
                        r_flush_exmem <= 1'b0;
                        r_busy        <= 1'b0;
                        // Only genuine redirects are counted; trap exits are not.
                        if ((r_state == ST_REDIRECT) && (r_count != c_CNT_MAX)) begin
                            r_count <= r_count + c_CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_pc_sel      <= 1'b0;
                    r_flush_ifid  <= 1'b0;
                    r_flush_idex  <= 1'b0;
                    r_flush_exmem <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign pc_sel         = r_pc_sel;
    assign pc_target      = r_target;
    assign flush_ifid     = r_flush_ifid;
    assign flush_idex     = r_flush_idex;
    assign flush_exmem    = r_flush_exmem;
    assign busy           = r_busy;
    assign misalign_err   = r_misalign_err;
    assign redirect_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Self-checking bench for branch_redirect_ctrl. Each cycle the
//               bench drives the inputs and computes the expected registered
//               outputs from a behavioural model. The result is queued and
//               then compared just after the clock edge. Directed checks
//               cover the documented example vectors.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_branch_redirect_ctrl;

    localparam logic [31:0] c_TRAP_VEC = 32'h0000_0004;
    localparam int          c_CNT_W    = 8;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};

    logic               clk;
    logic               rst;
    logic               ex_valid;
    logic [1:0]         ex_branch;
    logic [31:0]        ex_target;
    logic [31:0]        ex_jalr_target;
    logic               stall;
    logic               pc_sel;
    logic [31:0]        pc_target;
    logic               flush_ifid;
    logic               flush_idex;
    logic               flush_exmem;
    logic               busy;
    logic               misalign_err;
    logic [c_CNT_W-1:0] redirect_count;

    branch_redirect_ctrl #(
        .TRAP_VEC (c_TRAP_VEC),
        .CNT_W    (c_CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_target      (ex_target),
        .ex_jalr_target (ex_jalr_target),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .pc_target      (pc_target),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .flush_exmem    (flush_exmem),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               active;
        logic [31:0]        target;
        logic               err;
        logic [c_CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 IDLE, 1 REDIRECT, 2 TRAP
    int                 m_state = 0;
    logic [31:0]        m_target = 32'h0;
    logic               m_err = 1'b0;
    logic [c_CNT_W-1:0] m_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt32(input logic [c_CNT_W-1:0] c);
        return {{(32-c_CNT_W){1'b0}}, c};
    endfunction

    // One clock: drive inputs, run the model, queue the expectation, and
    // compare the outputs just after the edge.
    task automatic step(input logic v, input logic [1:0] b, input logic [31:0] t,
                        input logic [31:0] j, input logic s, input logic r);
        exp_t e;
        exp_t g;
        @(negedge clk);
        ex_valid       = v;
        ex_branch      = b;
        ex_target      = t;
        ex_jalr_target = j;
        stall          = s;
        rst            = r;

        if (r) begin
            m_state  = 0;
            m_target = 32'h0;
            m_err    = 1'b0;
            m_cnt    = '0;
        end else if (m_state == 0) begin
            if (v && !s && (b == 2'd1 || b == 2'd2)) begin
                if (b == 2'd2) begin
                    m_target = {j[31:1], 1'b0};
                    m_state  = 1;
                end else if (t[0]) begin
                    m_target = c_TRAP_VEC;
                    m_err    = 1'b1;
                    m_state  = 2;
                end else begin
                    m_target = t;
                    m_state  = 1;
                end
            end
        end else if (!s) begin
            if (m_state == 1 && m_cnt != c_CNT_MAX) m_cnt = m_cnt + 1'b1;
            m_state = 0;
        end

        e.active = (m_state != 0);
        e.target = m_target;
        e.err    = m_err;
        e.cnt    = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check_eq("pc_sel",       {31'b0, pc_sel},       {31'b0, g.active});
        check_eq("flush_ifid",   {31'b0, flush_ifid},   {31'b0, g.active});
        check_eq("flush_idex",   {31'b0, flush_idex},   {31'b0, g.active});
        check_eq("flush_exmem",  {31'b0, flush_exmem},  {31'b0, g.active});
        check_eq("busy",         {31'b0, busy},         {31'b0, g.active});
        check_eq("pc_target",    pc_target,             g.target);
        check_eq("misalign_err", {31'b0, misalign_err}, {31'b0, g.err});
        check_eq("count",        cnt32(redirect_count), cnt32(g.cnt));
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_branch = 2'd0;
        ex_target = 32'h0; ex_jalr_target = 32'h0; stall = 1'b0;

        // Reset, with a branch presented during reset that must be ignored
        step(1'b1, 2'd1, 32'h0000_0040, 32'h0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("rst_pc_target", pc_target, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'h0);

        // Taken branch to 0x100
        step(1'b1, 2'd1, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
        check_eq("br_pc_sel", {31'b0, pc_sel}, 32'h1);
        check_eq("br_target", pc_target, 32'h0000_0100);
        idle_step();
        check_eq("br_count", cnt32(redirect_count), 32'h1);
        check_eq("br_idle_sel", {31'b0, pc_sel}, 32'h0);

        // JALR clears bit 0 and never traps
        step(1'b1, 2'd2, 32'h0000_0001, 32'h0000_0203, 1'b0, 1'b0);
        check_eq("jalr_target", pc_target, 32'h0000_0202);
        check_eq("jalr_err", {31'b0, misalign_err}, 32'h0);
        idle_step();

        // Misaligned branch target -> trap; not counted; error sticky
        step(1'b1, 2'd1, 32'h0000_0101, 32'h0, 1'b0, 1'b0);
        check_eq("trap_target", pc_target, c_TRAP_VEC);
        check_eq("trap_err", {31'b0, misalign_err}, 32'h1);
        idle_step();
        check_eq("trap_count", cnt32(redirect_count), 32'h2);
        idle_step();
        check_eq("err_sticky", {31'b0, misalign_err}, 32'h1);

        // Stall while in REDIRECT, with a wrong-path branch presented
        step(1'b1, 2'd1, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd1, 32'h0000_0500, 32'h0, 1'b1, 1'b0);
            check_eq("stall_hold_target", pc_target, 32'h0000_0100);
        end
        step(1'b1, 2'd1, 32'h0000_0500, 32'h0, 1'b0, 1'b0);
        check_eq("stall_exit_sel", {31'b0, pc_sel}, 32'h0);
        check_eq("stall_exit_target", pc_target, 32'h0000_0100);
        idle_step();

        // A branch presented during a stall in IDLE is ignored until the stall is released
        step(1'b1, 2'd1, 32'h0000_0300, 32'h0, 1'b1, 1'b0);
        check_eq("idle_stall_sel", {31'b0, pc_sel}, 32'h0);
        step(1'b1, 2'd1, 32'h0000_0300, 32'h0, 1'b0, 1'b0);
        check_eq("idle_go_target", pc_target, 32'h0000_0300);

        // Reset takes priority over stall while in REDIRECT
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        check_eq("rst_redir_sel", {31'b0, pc_sel}, 32'h0);
        check_eq("rst_redir_err", {31'b0, misalign_err}, 32'h0);
        check_eq("rst_redir_cnt", cnt32(redirect_count), 32'h0);

        // Mixed random traffic, including codes 0 and 3 and occasional resets
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        // Counter saturation
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < (1 << c_CNT_W) + 4; i++) begin
            step(1'b1, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 1'b0);
            idle_step();
        end
        check_eq("cnt_saturate", cnt32(redirect_count), cnt32(c_CNT_MAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
